axi_mm_patchkr_mc: RTL and testbench

Multi-channel, parametrised pattern checker for the AXI-MM GPIO examples. It buffers expected beats from the local pattern generator and received beats from the link, each in its own synchronous FIFO. It compares them beat-by-beat with a per-channel enable mask and reports pass/fail/timeout, per-channel error flags, a saturating error count, and a first-error capture. It has two modes: burst (fixed beat count) and continuous (run until stop).

---
 rtl/axi_mm_patchkr_mc.sv | 147 ++++++++++++++
 tb/tb_axi_mm_patchkr_mc.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/axi_mm_patchkr_mc.sv
// axi_mm_patchkr_mc: multi-channel beat-by-beat pattern checker with expected/received FIFOs.
// Ports: rdclk/rst_n (sync, active-low); chk_start/chk_stop/chk_mode/exp_cnt/ch_en/tmo_lim run control;
// exp_* and rcv_* push interfaces (ready = FIFO not full); chk_busy, chk_status, err_cnt, ch_err,
// beat_cnt, first_err_idx, first_err_xor report results of the current or last run.
module axi_mm_patchkr_mc_fifo #(
  parameter int W     = 256,
  parameter int DEPTH = 512
) (
  input  logic         rdclk,
  input  logic         rst_n,
  input  logic         wr,
  input  logic [W-1:0] din,
  input  logic         rd,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wp, rp;
  assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign empty = wp == rp;
  assign dout  = mem[rp[AW-1:0]];
  always_ff @(posedge rdclk)
    if (wr && !full) mem[wp[AW-1:0]] <= din;
  always_ff @(posedge rdclk)
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (wr && !full) wp <= wp + 1'b1;
      if (rd && !empty) rp <= rp + 1'b1;
    end
endmodule

module axi_mm_patchkr_mc #(
  parameter int NUM_CH     = 4,
  parameter int LANE_W     = 64,
  parameter int FIFO_DEPTH = 512,
  parameter int ERR_W      = 16,
  parameter int TMO_W      = 16
) (
  input  logic                     rdclk,
  input  logic                     rst_n,
  input  logic                     chk_start,
  input  logic                     chk_stop,
  input  logic                     chk_mode,
  input  logic [ERR_W-1:0]         exp_cnt,
  input  logic [NUM_CH-1:0]        ch_en,
  input  logic [TMO_W-1:0]         tmo_lim,
  input  logic [NUM_CH*LANE_W-1:0] exp_data,
  input  logic                     exp_valid,
  output logic                     exp_ready,
  input  logic [NUM_CH*LANE_W-1:0] rcv_data,
  input  logic                     rcv_valid,
  output logic                     rcv_ready,
  output logic                     chk_busy,
  output logic [1:0]               chk_status,
  output logic [ERR_W-1:0]         err_cnt,
  output logic [NUM_CH-1:0]        ch_err,
  output logic [ERR_W-1:0]         beat_cnt,
  output logic [ERR_W-1:0]         first_err_idx,
  output logic [NUM_CH*LANE_W-1:0] first_err_xor
);
  localparam int DW = NUM_CH * LANE_W;
  typedef enum logic [1:0] {IDLE, RUN, DONE} st_t;
  st_t               st;
  logic              mode_l;
  logic [ERR_W-1:0]  exp_l;
  logic [NUM_CH-1:0] en_l;
  logic [TMO_W-1:0]  tmo, tmo_n;
  logic [DW-1:0]     e_head, r_head, xr;
  logic              e_full, e_empty, r_full, r_empty;
  logic              pop, bad, tmo_hit, fin;
  logic [NUM_CH-1:0] mm;
  logic [ERR_W-1:0]  beat_n, err_n;
  axi_mm_patchkr_mc_fifo #(.W(DW), .DEPTH(FIFO_DEPTH)) e_fifo (
    .rdclk(rdclk), .rst_n(rst_n), .wr(exp_valid), .din(exp_data), .rd(pop),
    .dout(e_head), .full(e_full), .empty(e_empty)
  );
  axi_mm_patchkr_mc_fifo #(.W(DW), .DEPTH(FIFO_DEPTH)) r_fifo (
    .rdclk(rdclk), .rst_n(rst_n), .wr(rcv_valid), .din(rcv_data), .rd(pop),
    .dout(r_head), .full(r_full), .empty(r_empty)
  );
  assign exp_ready = !e_full;
  assign rcv_ready = !r_full;
  assign chk_busy  = st == RUN;
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign xr[i*LANE_W +: LANE_W] = en_l[i] ? e_head[i*LANE_W +: LANE_W] ^ r_head[i*LANE_W +: LANE_W] : '0;
    assign mm[i] = |xr[i*LANE_W +: LANE_W];
  end
  // A finished burst must not pop again in its last RUN cycle (also covers exp_cnt == 0).
  always_comb begin
    pop     = chk_busy && !e_empty && !r_empty && !(!mode_l && beat_cnt == exp_l);
    bad     = pop && |mm;
    beat_n  = (pop && ~&beat_cnt) ? beat_cnt + 1'b1 : beat_cnt;
    err_n   = (bad && ~&err_cnt) ? err_cnt + 1'b1 : err_cnt;
    tmo_n   = pop ? '0 : tmo + 1'b1;
    tmo_hit = !pop && |tmo_lim && tmo_n == tmo_lim;
    fin     = mode_l ? chk_stop : beat_n == exp_l;
  end
  always_ff @(posedge rdclk)
    if (!rst_n) begin
      st            <= IDLE;
      mode_l        <= 1'b0;
      exp_l         <= '0;
      en_l          <= '0;
      tmo           <= '0;
      chk_status    <= 2'b00;
      err_cnt       <= '0;
      ch_err        <= '0;
      beat_cnt      <= '0;
      first_err_idx <= '0;
      first_err_xor <= '0;
    end else if (st != RUN) begin
      if (chk_start) begin
        st            <= RUN;
        mode_l        <= chk_mode;
        exp_l         <= exp_cnt;
        en_l          <= ch_en;
        tmo           <= '0;
        chk_status    <= 2'b00;
        err_cnt       <= '0;
        ch_err        <= '0;
        beat_cnt      <= '0;
        first_err_idx <= '0;
        first_err_xor <= '0;
      end
    end else begin
      beat_cnt <= beat_n;
      err_cnt  <= err_n;
      tmo      <= tmo_n;
      if (bad) ch_err <= ch_err | mm;
      // err_cnt saturates rather than wrapping, so zero reliably marks "no mismatch captured yet".
      if (bad && err_cnt == '0) begin
        first_err_idx <= beat_cnt;
        first_err_xor <= xr;
      end
      if (tmo_hit) begin
        st         <= DONE;
        chk_status <= 2'b01;
      end else if (fin) begin
        st         <= DONE;
        chk_status <= (err_n == '0) ? 2'b11 : 2'b10;
      end
    end
endmodule

// File: tb/tb_axi_mm_patchkr_mc.sv
// tb_axi_mm_patchkr_mc: directed scoreboard bench for axi_mm_patchkr_mc.
module tb_axi_mm_patchkr_mc;
  localparam int NC = 4, LW = 64, DW = 256, EW = 16, TW = 16;
  logic          rdclk = 1'b0, rst_n = 1'b0, chk_start = 1'b0, chk_stop = 1'b0, chk_mode = 1'b0;
  logic [EW-1:0] exp_cnt = '0;
  logic [NC-1:0] ch_en = '0;
  logic [TW-1:0] tmo_lim = '0;
  logic [DW-1:0] exp_data = '0, rcv_data = '0;
  logic          exp_valid = 1'b0, rcv_valid = 1'b0;
  logic          exp_ready, rcv_ready, chk_busy;
  logic [1:0]    chk_status;
  logic [EW-1:0] err_cnt, beat_cnt, first_err_idx;
  logic [NC-1:0] ch_err;
  logic [DW-1:0] first_err_xor;
  typedef struct {
    logic [1:0]    st;
    logic [EW-1:0] beats;
    logic [EW-1:0] errs;
    logic [EW-1:0] idx;
    logic [NC-1:0] ch;
    logic [DW-1:0] xr;
  } res_t;
  res_t          sb[$];
  res_t          rr;
  logic [DW-1:0] ea [600];
  logic [DW-1:0] ra [600];
  int            total = 0, passed = 0;

  axi_mm_patchkr_mc dut (
    .rdclk(rdclk), .rst_n(rst_n), .chk_start(chk_start), .chk_stop(chk_stop), .chk_mode(chk_mode),
    .exp_cnt(exp_cnt), .ch_en(ch_en), .tmo_lim(tmo_lim), .exp_data(exp_data), .exp_valid(exp_valid),
    .exp_ready(exp_ready), .rcv_data(rcv_data), .rcv_valid(rcv_valid), .rcv_ready(rcv_ready),
    .chk_busy(chk_busy), .chk_status(chk_status), .err_cnt(err_cnt), .ch_err(ch_err),
    .beat_cnt(beat_cnt), .first_err_idx(first_err_idx), .first_err_xor(first_err_xor)
  );

  always #5 rdclk = ~rdclk;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  task automatic tick;
    @(posedge rdclk);
    #1;
  endtask

  task automatic gen(input int n);
    for (int i = 0; i < n; i++) begin
      ea[i] = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      ra[i] = ea[i];
    end
  endtask

  task automatic push(input logic ve, input logic vr, input logic [DW-1:0] de, input logic [DW-1:0] dr);
    exp_valid = ve;
    rcv_valid = vr;
    exp_data  = de;
    rcv_data  = dr;
    tick;
    exp_valid = 1'b0;
    rcv_valid = 1'b0;
  endtask

  task automatic load(input int n);
    for (int i = 0; i < n; i++) push(1'b1, 1'b1, ea[i], ra[i]);
  endtask

  task automatic start(input logic m, input logic [EW-1:0] c, input logic [NC-1:0] en);
    chk_mode  = m;
    exp_cnt   = c;
    ch_en     = en;
    chk_start = 1'b1;
    tick;
    chk_start = 1'b0;
  endtask

  // Reference: walk the stored beats, compare enabled lanes, record first mismatch (0-based index).
  function automatic res_t model(input int n, input logic [NC-1:0] en);
    res_t          r;
    logic [NC-1:0] m;
    logic [DW-1:0] x;
    r.st = 2'b00; r.beats = '0; r.errs = '0; r.idx = '0; r.ch = '0; r.xr = '0;
    for (int b = 0; b < n; b++) begin
      m = '0;
      x = '0;
      for (int c = 0; c < NC; c++)
        if (en[c]) begin
          x[c*LW +: LW] = ea[b][c*LW +: LW] ^ ra[b][c*LW +: LW];
          m[c] = |x[c*LW +: LW];
        end
      if (|m) begin
        if (r.errs == '0) begin
          r.idx = EW'(b);
          r.xr  = x;
        end
        r.errs = r.errs + 1'b1;
        r.ch   = r.ch | m;
      end
    end
    r.beats = EW'(n);
    r.st    = (r.errs == '0) ? 2'b11 : 2'b10;
    return r;
  endfunction

  task automatic finish_run(input string tag);
    int k = 0;
    while (chk_busy && k < 5000) begin
      tick;
      k++;
    end
    total++;
    assert (!chk_busy) passed++;
    else $error("FAIL %s_done: busy observed %0b expected 0", tag, chk_busy);
    rr = sb.pop_front();
    chk({tag, "_status"}, DW'(chk_status), DW'(rr.st));
    chk({tag, "_beats"}, DW'(beat_cnt), DW'(rr.beats));
    chk({tag, "_errs"}, DW'(err_cnt), DW'(rr.errs));
    chk({tag, "_ch_err"}, DW'(ch_err), DW'(rr.ch));
    chk({tag, "_first_idx"}, DW'(first_err_idx), DW'(rr.idx));
    chk({tag, "_first_xor"}, first_err_xor, rr.xr);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_status"}, DW'(chk_status), '0);
    chk({tag, "_errs"}, DW'(err_cnt), '0);
    chk({tag, "_ch_err"}, DW'(ch_err), '0);
    chk({tag, "_beats"}, DW'(beat_cnt), '0);
    chk({tag, "_idx"}, DW'(first_err_idx), '0);
    chk({tag, "_xor"}, first_err_xor, '0);
    chk({tag, "_busy"}, DW'(chk_busy), '0);
    chk({tag, "_exp_ready"}, DW'(exp_ready), DW'(1));
    chk({tag, "_rcv_ready"}, DW'(rcv_ready), DW'(1));
  endtask

  initial begin
    res_t t;
    repeat (3) tick;
    chk_reset("rst");
    rst_n = 1'b1;
    tick;
    // all-matching burst of 8, with cycle-exact completion
    gen(8);
    load(8);
    sb.push_back(model(8, 4'b1111));
    start(1'b0, EW'(8), 4'b1111);
    repeat (7) tick;
    chk("t1_status_at7", DW'(chk_status), '0);
    chk("t1_beats_at7", DW'(beat_cnt), DW'(7));
    tick;
    chk("t1_status_at8", DW'(chk_status), DW'(3));
    finish_run("t1");
    // injected mismatches, all lanes enabled
    gen(8);
    ra[3][2*LW+5] = ~ra[3][2*LW+5];
    ra[6][0]      = ~ra[6][0];
    ra[6][2*LW+7] = ~ra[6][2*LW+7];
    load(8);
    sb.push_back(model(8, 4'b1111));
    start(1'b0, EW'(8), 4'b1111);
    finish_run("t2");
    chk("t2_xor_only_ch2b5", first_err_xor, DW'(1) << (2*LW+5));
    chk("t2_ch_err_const", DW'(ch_err), DW'(4'b0101));
    // same data, mismatching lanes masked off
    load(8);
    sb.push_back(model(8, 4'b1010));
    start(1'b0, EW'(8), 4'b1010);
    finish_run("t3");
    // timeout after 6 of 10 beats
    gen(10);
    tmo_lim = TW'(20);
    for (int i = 0; i < 10; i++) push(1'b1, i < 6, ea[i], ra[i]);
    t = model(6, 4'b1111);
    t.st = 2'b01;
    sb.push_back(t);
    start(1'b0, EW'(10), 4'b1111);
    repeat (25) tick;
    chk("t4_status_before_tmo", DW'(chk_status), '0);
    chk("t4_beats", DW'(beat_cnt), DW'(6));
    tick;
    chk("t4_status_tmo", DW'(chk_status), DW'(1));
    finish_run("t4");
    rst_n = 1'b0;
    tick;
    chk_reset("t4_rst");
    rst_n   = 1'b1;
    tmo_lim = '0;
    tick;
    // continuous run, error on the last beat, concurrent with stop
    gen(300);
    ra[299][LW+9] = ~ra[299][LW+9];
    load(300);
    sb.push_back(model(300, 4'b1111));
    start(1'b1, EW'(0), 4'b1111);
    repeat (299) tick;
    chk("t5_busy_before_stop", DW'(chk_busy), DW'(1));
    chk_stop = 1'b1;
    tick;
    chk_stop = 1'b0;
    finish_run("t5");
    // fill the expected FIFO, drop one extra push, then drain with 512 beats
    gen(512);
    for (int i = 0; i < 512; i++) push(1'b1, 1'b0, ea[i], '0);
    chk("t6_exp_ready_full", DW'(exp_ready), '0);
    chk("t6_rcv_ready", DW'(rcv_ready), DW'(1));
    push(1'b1, 1'b0, ~ea[0], '0);
    for (int i = 0; i < 512; i++) push(1'b0, 1'b1, '0, ra[i]);
    chk("t6_rcv_ready_full", DW'(rcv_ready), '0);
    sb.push_back(model(512, 4'b1111));
    start(1'b0, EW'(512), 4'b1111);
    finish_run("t6");
    // the dropped push must not be left in the expected FIFO: a lone received beat times out
    push(1'b0, 1'b1, '0, ea[0]);
    tmo_lim = TW'(5);
    t = model(0, 4'b1111);
    t.st = 2'b01;
    sb.push_back(t);
    start(1'b0, EW'(1), 4'b1111);
    finish_run("t7");
    // zero-length burst passes immediately
    sb.push_back(model(0, 4'b1111));
    start(1'b0, EW'(0), 4'b1111);
    finish_run("t8");
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
